// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// opcode/funct fields, internal ALU op codes and ALU control values.
package mips_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } statetype;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps the controller's 2-bit ALU op and the instruction funct
// field to the 3-bit ALU control word.
module aludec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: steps one instruction at a time through
// fetch/decode/execute/memory/writeback and drives the datapath controls.
module multicycle_controller
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcen,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  statetype state_q, state_d;

  logic   pcwrite, branch, op_legal;
  logic   memwrite_s, irwrite_s, regwrite_s, iord_s, memtoreg_s, regdst_s;
  logic   alusrca_s;
  logic [1:0] alusrcb_s, pcsrc_s;
  aluop_t aluop;

  // NOTE: state uses non-blocking assignment; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    pcwrite    = 1'b0;
    branch     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    iord_s     = 1'b0;
    memtoreg_s = 1'b0;
    regdst_s   = 1'b0;
    alusrca_s  = 1'b0;
    alusrcb_s  = 2'b00;
    pcsrc_s    = 2'b00;
    aluop      = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
        alusrcb_s = 2'b01;
      end
      DECODE:  alusrcb_s = 2'b11;
      MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      MEMRD:   iord_s = 1'b1;
      MEMWB: begin
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
      end
      RTYPEEX: begin
        alusrca_s = 1'b1;
        aluop     = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
      end
      BEQEX: begin
        alusrca_s = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc_s   = 2'b01;
        branch    = 1'b1;
      end
      ADDIEX: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      ADDIWB:  regwrite_s = 1'b1;
      JEX: begin
        pcsrc_s = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase

    // Reset overrides the decoded state: no writes, FETCH select values.
    if (reset) begin
      pcwrite    = 1'b0;
      branch     = 1'b0;
      memwrite_s = 1'b0;
      irwrite_s  = 1'b0;
      regwrite_s = 1'b0;
      iord_s     = 1'b0;
      memtoreg_s = 1'b0;
      regdst_s   = 1'b0;
      alusrca_s  = 1'b0;
      alusrcb_s  = 2'b01;
      pcsrc_s    = 2'b00;
      aluop      = ALUOP_ADD;
    end
  end

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  assign pcen     = pcwrite | (branch & zero);
  assign memwrite = memwrite_s;
  assign irwrite  = irwrite_s;
  assign regwrite = regwrite_s;
  assign iord     = iord_s;
  assign memtoreg = memtoreg_s;
  assign regdst   = regdst_s;
  assign alusrca  = alusrca_s;
  assign alusrcb  = alusrcb_s;
  assign pcsrc    = pcsrc_s;
  assign illegal  = (state_q == DECODE) && !op_legal && !reset;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction table, hand-written
// reset/illegal sequences and random instructions against a per-cycle model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal(illegal), .state(state)
  );

  typedef struct packed {
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
  } ctl_t;

  typedef struct {
    string      name;
    logic [5:0] op, funct;
    logic       zero;
    int         latency, n_pcen, n_regwrite, n_memwrite;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ctl_t observed();
    ctl_t c;
    c = '{pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
          alusrcb, pcsrc, alucontrol, illegal};
    return c;
  endfunction

  // Instruction classes and the states each one walks through.
  function automatic int step_state(input logic [5:0] o, input int i);
    int s[$];
    case (o)
      6'b100011: s = '{0, 1, 2, 3, 4};
      6'b101011: s = '{0, 1, 2, 5};
      6'b000000: s = '{0, 1, 6, 7};
      6'b001000: s = '{0, 1, 9, 10};
      6'b000100: s = '{0, 1, 8};
      6'b000010: s = '{0, 1, 11};
      default:   s = '{0, 1};
    endcase
    return (i < s.size()) ? s[i] : -1;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic ctl_t model_out(input int st, input logic [5:0] o,
                                     input logic [5:0] f, input logic z);
    ctl_t c;
    c = '0;
    c.alucontrol = 3'b010;
    case (st)
      0:  begin c.irwrite = 1; c.pcen = 1; c.alusrcb = 2'b01; end
      1:  begin c.alusrcb = 2'b11; c.illegal = (step_state(o, 2) < 0); end
      2:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      3:  c.iord = 1;
      4:  begin c.memtoreg = 1; c.regwrite = 1; end
      5:  begin c.iord = 1; c.memwrite = 1; end
      6:  begin c.alusrca = 1; c.alucontrol = funct_alu(f); end
      7:  begin c.regdst = 1; c.regwrite = 1; end
      8:  begin c.alusrca = 1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = z; end
      9:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      10: c.regwrite = 1;
      11: begin c.pcsrc = 2'b10; c.pcen = 1; end
      default: ;
    endcase
    return c;
  endfunction

  localparam ctl_t RESET_CTL = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0};

  // Entered just after a negedge with the DUT in FETCH; returns at the
  // negedge where the DUT is back in FETCH.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic z, output int cycles, output int n_pcen,
                           output int n_rw, output int n_mw);
    int exp_st;
    op = o; funct = f; zero = z;
    cycles = 0; n_pcen = 0; n_rw = 0; n_mw = 0;
    do begin
      #1;
      exp_st = step_state(o, cycles);
      check({name, " state"}, 32'(state), 32'(exp_st));
      check({name, " ctl"}, 32'(observed()), 32'(model_out(exp_st, o, f, z)));
      n_pcen += int'(pcen); n_rw += int'(regwrite); n_mw += int'(memwrite);
      cycles++;
      @(posedge clk); @(negedge clk);
    end while (state != 4'd0 && cycles < 10);
    check({name, " returns to FETCH"}, 32'(state), 32'd0);
  endtask

  vec_t vecs[$];
  int cyc, np, nr, nm;
  bit saw_memwb;
  logic [5:0] ops[6];
  logic [5:0] fns[5];

  initial begin
    vecs = '{
      '{"lw",       6'b100011, 6'b000000, 1'b0, 5, 1, 1, 0},
      '{"sw",       6'b101011, 6'b000000, 1'b0, 4, 1, 0, 1},
      '{"add",      6'b000000, 6'b100000, 1'b0, 4, 1, 1, 0},
      '{"sub",      6'b000000, 6'b100010, 1'b1, 4, 1, 1, 0},
      '{"and",      6'b000000, 6'b100100, 1'b0, 4, 1, 1, 0},
      '{"or",       6'b000000, 6'b100101, 1'b0, 4, 1, 1, 0},
      '{"slt",      6'b000000, 6'b101010, 1'b0, 4, 1, 1, 0},
      '{"addi",     6'b001000, 6'b000000, 1'b0, 4, 1, 1, 0},
      '{"beq_take", 6'b000100, 6'b000000, 1'b1, 3, 2, 0, 0},
      '{"beq_not",  6'b000100, 6'b000000, 1'b0, 3, 1, 0, 0},
      '{"j",        6'b000010, 6'b000000, 1'b0, 3, 2, 0, 0},
      '{"illegal",  6'b111111, 6'b000000, 1'b0, 2, 1, 0, 0}
    };
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    // Reset held two cycles.
    reset = 1'b1; op = 6'b100011; funct = '0; zero = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    check("reset state", 32'(state), 32'd0);
    check("reset ctl", 32'(observed()), 32'(RESET_CTL));
    reset = 1'b0;
    #1;
    check("post-reset irwrite", 32'(irwrite), 32'd1);
    check("post-reset pcen", 32'(pcen), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_instr(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].zero, cyc, np, nr, nm);
      check({vecs[i].name, " latency"}, 32'(cyc), 32'(vecs[i].latency));
      check({vecs[i].name, " pcen cycles"}, 32'(np), 32'(vecs[i].n_pcen));
      check({vecs[i].name, " regwrite cycles"}, 32'(nr), 32'(vecs[i].n_regwrite));
      check({vecs[i].name, " memwrite cycles"}, 32'(nm), 32'(vecs[i].n_memwrite));
    end

    // Reset during MEMRD of a lw aborts it before MEMWB.
    op = 6'b100011; funct = '0; zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("abort reach MEMRD", 32'(state), 32'd3);
    reset = 1'b1;
    #1;
    check("abort ctl during reset", 32'(observed()), 32'(RESET_CTL));
    saw_memwb = 1'b0;
    @(negedge clk);
    #1;
    check("abort state FETCH", 32'(state), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (state == 4'd4) saw_memwb = 1'b1;
      @(negedge clk);
    end
    check("abort MEMWB never entered", 32'(saw_memwb), 32'd0);
    // Restarted lw now sits in MEMADR; let it drain.
    repeat (3) @(negedge clk);
    check("abort drained to FETCH", 32'(state), 32'd0);

    // Random instructions, mostly legal.
    for (int n = 0; n < 60; n++) begin
      logic [5:0] ro, rf;
      logic rz;
      ro = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      rz = 1'($urandom);
      run_instr("random", ro, rf, rz, cyc, np, nr, nm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives every datapath enable and mux select from the instruction register's op/funct fields and the ALU zero flag.
- Instantiated inside the mips core next to the datapath. One instruction is in flight at a time; there is no pipelining.

Parameters:
- STATE_W, 4, width of state register and debug state port (fixed by encoding in package)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- op  input  6  instr[31:26] from instruction register
- funct  input  6  instr[5:0] from instruction register
- zero  input  1  ALU zero flag from datapath
- pcen  output  1  PC register enable
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register enable
- regwrite  output  1  register file write enable
- iord  output  1  memory address select (0=PC, 1=ALUOut)
- memtoreg  output  1  writeback select (0=ALUOut, 1=Data reg)
- regdst  output  1  destination select (0=rt, 1=rd)
- alusrca  output  1  ALU A select (0=PC, 1=A reg)
- alusrcb  output  2  ALU B select (00=B, 01=4, 10=SignImm, 11=SignImm<<2)
- pcsrc  output  2  next-PC select (00=ALUResult, 01=ALUOut, 10=jump target)
- alucontrol  output  3  ALU operation
- illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode
- state  output  4  current state, debug only

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
  - reset sampled high at a rising edge sets state to FETCH.
  - While reset is high, pcen, memwrite, irwrite, regwrite and illegal are forced to 0. All selects take their FETCH values.
  - Reset asserted mid-instruction aborts that instruction: no further writes occur, and it restarts at FETCH.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
  - Codes 12-15 go to FETCH on the next edge with all enables 0.
- Transitions:
  - FETCH->DECODE.
  - DECODE->MEMADR on lw(100011) or sw(101011); RTYPEEX on 000000; BEQEX on beq(000100); ADDIEX on addi(001000); JEX on j(000010). Any other opcode goes to FETCH with illegal=1 and is treated as a NOP.
  - MEMADR->MEMRD for lw, MEMWR for sw.
  - MEMRD->MEMWB.
  - RTYPEEX->RTYPEWB.
  - ADDIEX->ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX all go to FETCH.
- Latency (cycles including FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Moore outputs per state. Anything not listed is 0.
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- pcen = pcwrite | (branch & zero). This is combinational; zero is sampled in BEQEX only.
- ALU decode (combinational, internal 2-bit aluop):
  - 00 -> 010 (add); 01 -> 110 (sub).
  - 10 -> funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111. Any other funct -> 010.
- op/funct must be stable from DECODE to the end of the instruction. irwrite is asserted only in FETCH.

Decomposition:
- Shared package mips_pkg holds:
  - statetype enum with the encoding above;
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J;
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT;
  - ALU op codes.
- One sub-module, aludec: aluop + funct -> alucontrol, purely combinational.
- The FSM and output decode stay in multicycle_controller.

Test Plan:
- Reset: hold reset 2 cycles -> state=0, pcen=memwrite=irwrite=regwrite=0. First cycle after release: irwrite=1, pcen=1, alusrcb=01.
- lw (op=100011): state sequence 0,1,2,3,4. iord=1 in MEMRD; memtoreg=1 and regwrite=1 only in MEMWB; memwrite never 1.
- sw (op=101011): states 0,1,2,5. memwrite=1 and iord=1 for exactly one cycle at cycle 4, matching the datapath's write of 7 to address 84. regwrite never 1.
- beq (op=000100) with zero=1 -> pcen=1, pcsrc=01, alucontrol=110 in BEQEX. Repeat with zero=0 -> pcen=0 in BEQEX.
- R-type funct sweep 100000/100010/100100/100101/101010 -> alucontrol 010/110/000/001/111 in RTYPEEX; RTYPEWB has regdst=1, regwrite=1. addi -> ADDIEX alusrcb=10, ADDIWB regdst=0. j -> JEX pcsrc=10, pcen=1.
- Illegal op=111111 -> illegal=1 for one cycle in DECODE, then FETCH, no writes. Reset asserted during MEMRD -> next state FETCH, MEMWB never entered.
